mips_regfile_param: RTL and testbench
=====================================

# mips_regfile_param

Parametrised successor to the single-cycle processor's 8×32 register file: configurable data width and register count, two combinational read ports, one clocked write port, hardwired zero register. Adds a write acknowledge, a hardware sweep-clear sequencer that zeroes the array one entry per cycle, and optional write-to-read bypass. Sits between decode (read addresses), writeback (write port) and the processor's reset/initialisation control.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 3: address width; `DEPTH` = 2^ADDR_W entries.
- `ZERO_REG`, default 1: 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register.
- Clocking and reset (decided): one clock; reset is asynchronous and active-high.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `read_reg_1`  in  ADDR_W  port-1 read address.
- `read_reg_2`  in  ADDR_W  port-2 read address.
- `read_data_1`  out  DATA_W  port-1 data, combinational.
- `read_data_2`  out  DATA_W  port-2 data, combinational.
- `write_reg`  in  ADDR_W  write address.
- `write_data`  in  DATA_W  write data.
- `signal_reg_write`  in  1  write enable, sampled on the `clk` rising edge.
- `clear_req`  in  1  single-cycle pulse that starts a sweep clear.
- `clear_busy`  out  1  high while the sweep is in progress.
- `write_ack`  out  1  registered; high for one cycle after an accepted write.

## Operation
- **Reset:**
  - `rst` high clears every entry to 0 immediately, with no clock needed.
  - State goes to IDLE and the sweep counter to 0.
  - `clear_busy` = 0 and `write_ack` = 0.
  - `read_data_1`/`read_data_2` therefore read 0.
- **Reads:**
  - `read_data_n` = array[`read_reg_n`].
  - Forced to 0 when `ZERO_REG`=1 and the address is 0.
  - Both ports may address the same entry at once.
- **Writes:**
  - Accepted when `signal_reg_write`=1 and the state is IDLE.
  - An accepted write stores `write_data` at `write_reg` on the edge.
  - A write to entry 0 with `ZERO_REG`=1 is accepted and acknowledged, but the data is discarded.
- **`write_ack`:** 1 in the cycle after any accepted write; otherwise 0.
- **FSM states:** IDLE and CLEAR.
  - IDLE → CLEAR on an edge with `clear_req`=1. The counter loads 0.
  - In CLEAR, each edge writes 0 to array[counter] and increments the counter.
  - The edge that clears entry DEPTH−1 returns the FSM to IDLE; the counter wraps to 0.
- **During CLEAR:**
  - `signal_reg_write` is ignored: no store and no ack. Writeback must stall on `clear_busy`.
  - `clear_req` is ignored.
  - Reads return the current array contents, i.e. partially cleared data.
- **Simultaneous events:**
  - `clear_req` and an accepted write on the same IDLE edge: the write commits and is acked.
  - The sweep then starts and later zeroes that entry too.
- **Reset mid-sweep:** the array is zeroed and the FSM returns to IDLE at once.

## Timing
- Write-to-read latency: 1 edge. Data is visible combinationally in the cycle after the edge; see bypass under Configuration.
- `clear_busy` is high for exactly DEPTH cycles, starting the cycle after `clear_req` is sampled. Example: DEPTH=8 gives 8 cycles.
- The first write is accepted on the edge at which `clear_busy` is sampled 0.
- `write_ack` lags the accepting edge by exactly one cycle. Back-to-back writes give a continuous high ack.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** in IDLE with `signal_reg_write`=1, any read port whose address equals `write_reg` returns `write_data` combinationally in the same cycle.
  - Exception: the bypass does not apply when the address is 0 and `ZERO_REG`=1; that port returns 0.
  - No bypass during CLEAR.
- **Undefined:** reads return the stored value until the write edge (1-cycle latency).

## Structure
- Package `mips_regfile_pkg` holds:
  - the state enum `regfile_state_t` {IDLE, CLEAR};
  - a `depth_f(ADDR_W)` constant function.
- Sub-module `mips_regfile_clear_seq` holds the FSM, the ADDR_W-bit counter and `clear_busy`. It outputs the clear-write enable and address.
- The top module holds the array, write mux, read/bypass logic and `write_ack`.

## Test plan
- Assert `rst` mid-cycle, no clock edge → all reads 0 at once; `clear_busy`=0, `write_ack`=0.
- Write 32'h3333_3330 to reg 2, then read ports 2 and 6 → next cycle `read_data_1`=32'h3333_3330; `write_ack`=1 for one cycle.
- `ZERO_REG`=1, write 32'hFFFF_FFFF to reg 0 → `read_data`(0)=0 and `write_ack`=1.
- Preload regs 1–7 with nonzero values, pulse `clear_req` → `clear_busy` high 8 cycles; reg k reads 0 after the (k+1)th edge; writes issued during the sweep give no ack and no store.
- `REGFILE_BYPASS_EN` on, write 32'hA5A5_A5A5 to reg 4 while reading 4 on both ports → both ports show A5A5_A5A5 in the same cycle. Without the macro → old value, then A5A5_A5A5 next cycle.
- Assert `rst` during the 4th sweep cycle → immediate IDLE, all entries 0; a write on the next edge is accepted.

Source files
------------

// File: rtl/mips_regfile_pkg.sv
// mips_regfile_pkg: shared types and helpers for the parametrised MIPS
// register file.
//   regfile_state_t : sweep-clear sequencer states (IDLE, CLEAR)
//   depth_f()       : number of entries for a given address width
package mips_regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regfile_state_t;

    function automatic int depth_f(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/mips_regfile_clear_seq.sv
// mips_regfile_clear_seq: sweep-clear sequencer. On a clear request it walks
// every entry once, one entry per cycle, and raises a clear-write strobe for
// the register array.
// Ports:
//   clk        in   sole clock (rising edge)
//   rst        in   asynchronous active-high reset
//   clear_req  in   start pulse, honoured only in IDLE
//   clear_busy out  high while the sweep is running (DEPTH cycles)
//   clear_we   out  array clear-write enable
//   clear_addr out  entry being zeroed this cycle
module mips_regfile_clear_seq
    import mips_regfile_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr
);

    regfile_state_t    state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    // The counter wraps to 0 on the edge that clears the
                    // last entry, which is also the edge that leaves CLEAR.
                    cnt <= cnt + 1'b1;
                    if (cnt == {ADDR_W{1'b1}}) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign clear_busy = (state == CLEAR);
    assign clear_we   = (state == CLEAR);
    assign clear_addr = cnt;

endmodule

// File: rtl/mips_regfile_param.sv
// mips_regfile_param: parametrised register file with two combinational read
// ports, one clocked write port, optional hardwired zero register, a write
// acknowledge and a hardware sweep-clear.
// Optional feature: define REGFILE_BYPASS_EN to forward write_data to a read
// port addressing write_reg in the same cycle (IDLE only).
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   read_reg_1/2, read_data_1/2 read addresses and combinational data
//   write_reg, write_data       write address and data
//   signal_reg_write            write enable
//   clear_req                   start a sweep clear
//   clear_busy                  sweep in progress; writes are ignored
//   write_ack                   one cycle after each accepted write
module mips_regfile_param
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              signal_reg_write,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              write_ack
);

    localparam int DEPTH = depth_f(ADDR_W);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;
    logic              accept;
    logic              store;

    mips_regfile_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    // A write to the zero register is still accepted (and acked); only the
    // store is suppressed.
    assign accept = signal_reg_write && !clear_busy;
    assign store  = accept && !((ZERO_REG != 0) && (write_reg == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clear_we) begin
            regs[clear_addr] <= '0;
        end else if (store) begin
            regs[write_reg] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_ack <= 1'b0;
        end else begin
            write_ack <= accept;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs[addr];
`ifdef REGFILE_BYPASS_EN
        // accept already excludes CLEAR, so no forwarding during the sweep.
        if (accept && (addr == write_reg)) begin
            val = write_data;
        end
`endif
        if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    assign read_data_1 = read_port(read_reg_1);
    assign read_data_2 = read_port(read_reg_2);

endmodule

// File: tb/tb_mips_regfile_param.sv
`timescale 1ns/1ps
module tb_mips_regfile_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] read_reg_1;
    logic [ADDR_W-1:0] read_reg_2;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              signal_reg_write;
    logic              clear_req;
    logic              clear_busy;
    logic              write_ack;

    int vectors;
    int miscompares;

    // Reference model: register contents, sweep progress, expected ack.
    logic [DATA_W-1:0] m [DEPTH];
    bit                m_busy;
    int                m_cnt;
    bit                m_ack;

    mips_regfile_param #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .read_reg_1       (read_reg_1),
        .read_reg_2       (read_reg_2),
        .read_data_1      (read_data_1),
        .read_data_2      (read_data_2),
        .write_reg        (write_reg),
        .write_data       (write_data),
        .signal_reg_write (signal_reg_write),
        .clear_req        (clear_req),
        .clear_busy       (clear_busy),
        .write_ack        (write_ack)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        m_busy = 0;
        m_cnt  = 0;
        m_ack  = 0;
    endtask

    // Expected combinational value at a read port given current inputs.
    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!m_busy && signal_reg_write && a == write_reg) return write_data;
`endif
        return m[a];
    endfunction

    // Advance the model by one edge using the currently driven inputs, then
    // let the DUT take the same edge; returns 1 ns after the edge.
    task automatic tick();
        bit acc;
        acc = signal_reg_write && !m_busy;
        if (m_busy) begin
            m[m_cnt] = '0;
            if (m_cnt == DEPTH - 1) begin
                m_busy = 0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            if (acc && write_reg != 0) m[write_reg] = write_data;
            if (clear_req) begin
                m_busy = 1;
                m_cnt  = 0;
            end
        end
        m_ack = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        write_reg = a;
        write_data = d;
        signal_reg_write = 1'b1;
        tick();
        signal_reg_write = 1'b0;
    endtask

    task automatic test_reset();
        do_write(3'd5, 32'h1234_5678);
        do_write(3'd1, 32'hCAFE_0001);
        read_reg_1 = 3'd5;
        read_reg_2 = 3'd1;
        #4;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_reads: got %h %h want 0 0", read_data_1, read_data_2);
        end
        vectors++;
        if (clear_busy !== 1'b0 || write_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy=%b ack=%b want 0 0", clear_busy, write_ack);
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_reg_1 = a[ADDR_W-1:0];
            #1;
            vectors++;
            if (read_data_1 !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_entry%0d: got %h want 0", a, read_data_1);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        read_reg_1 = 3'd2;
        read_reg_2 = 3'd6;
        do_write(3'd2, 32'h3333_3330);
        vectors++;
        if (read_data_1 !== 32'h3333_3330 || read_data_2 !== exp_read(3'd6)) begin
            miscompares++;
            $display("FAIL write_read: got %h %h want 33333330 %h", read_data_1, read_data_2, exp_read(3'd6));
        end
        vectors++;
        if (write_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL write_ack_high: got %b want 1", write_ack);
        end
        tick();
        vectors++;
        if (write_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL write_ack_drop: got %b want 0", write_ack);
        end
    endtask

    task automatic test_zero_reg();
        read_reg_1 = 3'd0;
        read_reg_2 = 3'd0;
        do_write(3'd0, 32'hFFFF_FFFF);
        vectors++;
        if (read_data_1 !== 32'h0 || write_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_reg: data=%h ack=%b want 0 1", read_data_1, write_ack);
        end
        tick();
    endtask

    task automatic test_clear();
        int busy_cycles;
        for (int k = 1; k < DEPTH; k++) do_write(k[ADDR_W-1:0], $urandom | 32'h1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (clear_busy === 1'b1) busy_cycles++;
            vectors++;
            if (clear_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL clear_busy_cyc%0d: got %b want 1", i, clear_busy);
            end
            // entry i is zeroed on this edge; entry i+1 must still hold data
            read_reg_1 = i[ADDR_W-1:0];
            read_reg_2 = (i + 1) % DEPTH;
            write_reg = $urandom_range(1, DEPTH - 1);
            write_data = $urandom;
            signal_reg_write = 1'b1;
            tick();
            signal_reg_write = 1'b0;
            vectors++;
            if (write_ack !== 1'b0 || read_data_1 !== 32'h0 || read_data_2 !== exp_read(read_reg_2)) begin
                miscompares++;
                $display("FAIL clear_step%0d: ack=%b rd1=%h rd2=%h want 0 0 %h",
                         i, write_ack, read_data_1, read_data_2, exp_read(read_reg_2));
            end
        end
        vectors++;
        if (clear_busy !== 1'b0 || busy_cycles != DEPTH) begin
            miscompares++;
            $display("FAIL clear_length: busy=%b cycles=%0d want 0 %0d", clear_busy, busy_cycles, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_reg_1 = a[ADDR_W-1:0];
            #1;
            vectors++;
            if (read_data_1 !== 32'h0) begin
                miscompares++;
                $display("FAIL clear_entry%0d: got %h want 0", a, read_data_1);
            end
        end
    endtask

    task automatic test_clear_with_write();
        read_reg_1 = 3'd3;
        write_reg = 3'd3;
        write_data = 32'h0BAD_F00D;
        signal_reg_write = 1'b1;
        clear_req = 1'b1;
        tick();
        signal_reg_write = 1'b0;
        clear_req = 1'b0;
        vectors++;
        if (write_ack !== 1'b1 || clear_busy !== 1'b1 || read_data_1 !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL clear_and_write: ack=%b busy=%b rd=%h want 1 1 0badf00d",
                     write_ack, clear_busy, read_data_1);
        end
        repeat (DEPTH) tick();
        vectors++;
        if (read_data_1 !== 32'h0 || clear_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_and_write_end: rd=%h busy=%b want 0 0", read_data_1, clear_busy);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] want_now;
        do_write(3'd4, 32'h1111_2222);
        read_reg_1 = 3'd4;
        read_reg_2 = 3'd4;
        write_reg = 3'd4;
        write_data = 32'hA5A5_A5A5;
        signal_reg_write = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        want_now = 32'hA5A5_A5A5;
`else
        want_now = 32'h1111_2222;
`endif
        vectors++;
        if (read_data_1 !== want_now || read_data_2 !== want_now) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got %h %h want %h", read_data_1, read_data_2, want_now);
        end
        tick();
        signal_reg_write = 1'b0;
        vectors++;
        if (read_data_1 !== 32'hA5A5_A5A5 || read_data_2 !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("FAIL bypass_next_cycle: got %h %h want a5a5a5a5", read_data_1, read_data_2);
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int k = 1; k < DEPTH; k++) do_write(k[ADDR_W-1:0], 32'h5000_0000 + k);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (3) tick();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (clear_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midsweep_busy: got %b want 0", clear_busy);
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_reg_1 = a[ADDR_W-1:0];
            #1;
            vectors++;
            if (read_data_1 !== 32'h0) begin
                miscompares++;
                $display("FAIL midsweep_entry%0d: got %h want 0", a, read_data_1);
            end
        end
        rst = 1'b0;
        read_reg_1 = 3'd6;
        do_write(3'd6, 32'h6666_0006);
        vectors++;
        if (write_ack !== 1'b1 || read_data_1 !== 32'h6666_0006) begin
            miscompares++;
            $display("FAIL midsweep_write: ack=%b rd=%h want 1 66660006", write_ack, read_data_1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            read_reg_1 = $urandom;
            read_reg_2 = $urandom;
            write_reg = $urandom;
            write_data = $urandom;
            signal_reg_write = $urandom_range(0, 2) != 0;
            clear_req = $urandom_range(0, 19) == 0;
            #1;
            vectors++;
            if (read_data_1 !== exp_read(read_reg_1) || read_data_2 !== exp_read(read_reg_2)) begin
                miscompares++;
                $display("FAIL random_read%0d: got %h %h want %h %h", n, read_data_1, read_data_2,
                         exp_read(read_reg_1), exp_read(read_reg_2));
            end
            tick();
            vectors++;
            if (write_ack !== m_ack || clear_busy !== m_busy) begin
                miscompares++;
                $display("FAIL random_ctrl%0d: ack=%b busy=%b want %b %b", n, write_ack, clear_busy,
                         m_ack, m_busy);
            end
        end
        signal_reg_write = 1'b0;
        clear_req = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        read_reg_1 = '0;
        read_reg_2 = '0;
        write_reg = '0;
        write_data = '0;
        signal_reg_write = 1'b0;
        clear_req = 1'b0;
        model_reset();
        #25;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_clear();
        test_clear_with_write();
        test_bypass();
        test_reset_mid_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
